// File: rtl/parity_stream_pkg.sv
// Shared constants and types for the lane-parity stream block.
package parity_stream_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Flag vector sized for the default 4-lane configuration.
    localparam int LANES_DEF = 4;
    typedef logic [LANES_DEF-1:0] lane_flags_t;

    function automatic int lane_w(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/parity_lane_calc.sv
// Combinational XOR-reduction parity for one lane, even or odd sense.
module parity_lane_calc
    import parity_stream_pkg::*;
#(
    parameter int LW = 8
) (
    input  logic [LW-1:0] lane_data_i,
    input  logic          odd_mode_i,
    output logic          par_o
);

    assign par_o = (^lane_data_i) ^ (odd_mode_i == PAR_ODD);

endmodule

// File: rtl/parity_stream_lanes.sv
// Per-lane parity generate/check on a valid/ready stream with one register stage.
// Optional saturating error-beat counter enabled by PARITY_STREAM_ERR_CNT_EN.
module parity_stream_lanes
    import parity_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              chk_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [LANES-1:0]  s_par,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [LANES-1:0]  m_par,
    output logic [LANES-1:0]  m_err,
    output logic              err_sticky,
`ifdef PARITY_STREAM_ERR_CNT_EN
    output logic [CNT_W-1:0]  err_cnt,
`endif
    input  logic              err_clr
);

    localparam int LW = lane_w(DATA_W, LANES);

    if ((DATA_W % LANES) != 0 || CNT_W < 1) begin : g_bad_cfg
        $error("parity_stream_lanes: DATA_W must be a multiple of LANES and CNT_W >= 1");
    end

    logic [LANES-1:0]  par_calc;
    logic [LANES-1:0]  err_next;
    logic              accept;
    logic              out_fire;
    logic              beat_err;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [LANES-1:0]  m_par_q,   m_par_d;
    logic [LANES-1:0]  m_err_q,   m_err_d;
    logic              sticky_q,  sticky_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parity_lane_calc #(.LW(LW)) u_calc (
            .lane_data_i (s_data[k*LW +: LW]),
            .odd_mode_i  (odd_mode),
            .par_o       (par_calc[k])
        );
    end

    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign out_fire = m_valid_q && m_ready;
    assign err_next = chk_en ? (par_calc ^ s_par) : '0;
    assign beat_err = accept && (|err_next);

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_par_d   = m_par_q;
        m_err_d   = m_err_q;
        sticky_d  = sticky_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_par_d   = par_calc;
            m_err_d   = err_next;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
        // A new error on the same edge as a clear leaves the flag set.
        if (beat_err) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_par_q   <= '0;
            m_err_q   <= '0;
            sticky_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_par_q   <= m_par_d;
            m_err_q   <= m_err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_par      = m_par_q;
    assign m_err      = m_err_q;
    assign err_sticky = sticky_q;

`ifdef PARITY_STREAM_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

    // Clear first, then increment, so clear plus error yields 1.
    always_comb begin
        cnt_base = err_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (beat_err && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_parity_stream_lanes.sv
// Directed self-checking bench for parity_stream_lanes (DATA_W=32, LANES=4).
module tb_parity_stream_lanes;
    import parity_stream_pkg::*;

`ifdef PARITY_STREAM_ERR_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n, odd_mode, chk_en, s_valid, s_ready, m_valid, m_ready;
    logic        err_sticky, err_clr;
    logic [31:0] s_data, m_data;
    lane_flags_t s_par, m_par, m_err;
`ifdef PARITY_STREAM_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    parity_stream_lanes #(.DATA_W(32), .LANES(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .odd_mode   (odd_mode),
        .chk_en     (chk_en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_par      (s_par),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_par      (m_par),
        .m_err      (m_err),
        .err_sticky (err_sticky),
`ifdef PARITY_STREAM_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [7:0]  b;

        rst_n = 1'b0; odd_mode = PAR_EVEN; chk_en = 1'b0; s_valid = 1'b0;
        s_data = '0; s_par = '0; m_ready = 1'b1; err_clr = 1'b0;
        step();
        step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_par", m_par, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_s_ready", s_ready, 1);
`ifdef PARITY_STREAM_ERR_CNT_EN
        chk("rst_cnt", err_cnt, 0);
`endif

        // Even parity, generate only
        rst_n = 1'b1; s_valid = 1'b1; s_data = 32'h0103_07FF;
        step();
        chk("even_m_valid", m_valid, 1);
        chk("even_m_data", m_data, 32'h0103_07FF);
        chk("even_m_par", m_par, 4'b1010);
        chk("even_m_err", m_err, 0);
        chk("even_sticky", err_sticky, 0);

        // Odd parity, same data
        odd_mode = PAR_ODD;
        step();
        chk("odd_m_par", m_par, 4'b0101);
        chk("odd_m_err", m_err, 0);

        // Check mode with lane 0 mismatching
        odd_mode = PAR_EVEN; chk_en = 1'b1; s_par = 4'b1011;
        step();
        chk("chk_m_par", m_par, 4'b1010);
        chk("chk_m_err", m_err, 4'b0001);
        chk("chk_sticky", err_sticky, 1);

        // Ten clean beats keep the flag set
        s_par = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("clean_m_err", m_err, 0);
            chk("clean_sticky", err_sticky, 1);
        end

        // Backpressure: held beat stays put, odd_mode change ignored
        m_ready = 1'b0; chk_en = 1'b0; s_data = 32'hDEAD_BEEF;
        held = 32'h0103_07FF;
        for (int i = 0; i < 3; i++) begin
            odd_mode = (i == 1) ? PAR_ODD : PAR_EVEN;
            #1;
            chk("stall_s_ready", s_ready, 0);
            step();
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, held);
            chk("stall_m_par", m_par, 4'b1010);
        end

        // Eight back-to-back beats, each byte lane = i
        m_ready = 1'b1; odd_mode = PAR_EVEN;
        for (int i = 0; i < 8; i++) begin
            b = 8'(i);
            s_data = {b, b, b, b};
            #1;
            chk("b2b_s_ready", s_ready, 1);
            step();
            chk("b2b_m_valid", m_valid, 1);
            chk("b2b_m_data", m_data, {b, b, b, b});
            chk("b2b_m_par", m_par, {4{^b}});
        end

        s_valid = 1'b0;
        step();
        chk("drain_m_valid", m_valid, 0);
        chk("drain_s_ready", s_ready, 1);

        // Clear alone, then clear vs set, then clear alone
        err_clr = 1'b1;
        step();
        chk("clr_sticky", err_sticky, 0);
        s_valid = 1'b1; chk_en = 1'b1; s_data = 32'h0103_07FF; s_par = 4'b1011;
        step();
        chk("clrset_sticky", err_sticky, 1);
        chk("clrset_m_err", m_err, 4'b0001);
`ifdef PARITY_STREAM_ERR_CNT_EN
        chk("clrset_cnt", err_cnt, 1);
`endif
        s_valid = 1'b0;
        step();
        chk("clr2_sticky", err_sticky, 0);
        err_clr = 1'b0;
`ifdef PARITY_STREAM_ERR_CNT_EN
        chk("clr2_cnt", err_cnt, 0);
        // Five erroring beats saturate a 2-bit counter at 3
        s_valid = 1'b1;
        step();
        chk("cnt_first", err_cnt, 1);
        for (int i = 0; i < 4; i++) step();
        chk("cnt_sat", err_cnt, 3);
        s_valid = 1'b0;
        step();
`endif

        // Reset mid-stall discards the held beat
        m_ready = 1'b0; s_valid = 1'b1; chk_en = 1'b1; s_par = 4'b1011;
        step();
        chk("pre_rst_m_valid", m_valid, 1);
        chk("pre_rst_sticky", err_sticky, 1);
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_m_err", m_err, 0);
        chk("midrst_sticky", err_sticky, 0);
`ifdef PARITY_STREAM_ERR_CNT_EN
        chk("midrst_cnt", err_cnt, 0);
`endif
        rst_n = 1'b1; s_valid = 1'b0;
        step();
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_s_ready", s_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_stream_lanes.md
Name: parity_stream_lanes

Overview:
- Parametrised, pipelined successor to the single-byte XOR-reduction parity block.
- Splits a DATA_W word into LANES equal lanes and computes per-lane even/odd parity.
- Optionally checks each lane against received parity bits, and tracks errors in a sticky flag and an optional saturating counter.
- Sits between a source and sink on a valid/ready stream (bus protection on links and memory ports), with one register stage.

Parameters:
- DATA_W, 32, total data width; must be a multiple of LANES.
- LANES, 4, number of parity lanes; lane width LW = DATA_W/LANES.
- CNT_W, 8, width of the error counter (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- odd_mode  in  1  0 = even parity, 1 = odd parity; quasi-static.
- chk_en  in  1  1 = compare against s_par; 0 = generate only.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  DATA_W  input data; lane k = bits [k*LW +: LW].
- s_par  in  LANES  received parity per lane; ignored when chk_en = 0.
- m_valid  out  1  output beat valid.
- m_ready  in  1  sink accepts the beat.
- m_data  out  DATA_W  registered copy of s_data.
- m_par  out  LANES  computed parity per lane.
- m_err  out  LANES  per-lane mismatch for this beat.
- err_sticky  out  1  set on any lane error; held until cleared.
- err_clr  in  1  synchronous clear of err_sticky (and the counter).

Behaviour:
- Reset (rst_n = 0 at a clk edge): m_valid = 0, m_data = 0, m_par = 0, m_err = 0, err_sticky = 0, counter = 0. s_ready = 1 the cycle after reset.
- s_ready = !m_valid || m_ready. This is combinational; there is no combinational path from s_valid to s_ready.
- Transfer in: s_valid && s_ready at the edge. The output register loads m_data, m_par and m_err, and sets m_valid = 1. Latency is exactly 1 cycle.
- Transfer out: m_valid && m_ready. If no new beat is loaded in the same cycle, m_valid clears next cycle.
- Simultaneous in and out: the register reloads and m_valid stays 1. This gives full throughput of 1 beat per cycle.
- Stall (m_valid && !m_ready): m_data, m_par and m_err hold stable; s_ready = 0.
- Parity: m_par[k] = (XOR reduction of lane k) ^ odd_mode.
- Error: m_err[k] = chk_en & (m_par[k] ^ s_par[k]), computed from the values sampled with the beat. When chk_en = 0, m_err = 0.
- Sticky: err_sticky sets on the edge that loads a beat with |m_err_next. It is evaluated on input acceptance, not output.
- err_clr: clears err_sticky. If err_clr coincides with a new error beat, the set wins (err_sticky = 1).
- Mid-stream reset: any in-flight beat is discarded; no partial state survives.
- odd_mode and chk_en are sampled per accepted beat; changing them mid-stall does not alter the held beat.

Optional Feature:
- Macro: PARITY_STREAM_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt [CNT_W].
  - err_cnt increments by 1 per accepted beat with any lane error; it counts beats, not lanes.
  - err_cnt saturates at all-ones.
  - err_clr zeroes it; clear and increment in the same cycle gives 1.
  - Reset value is 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package parity_stream_pkg holds:
  - the localparam function for lane width;
  - parity mode constants PAR_EVEN = 1'b0 and PAR_ODD = 1'b1;
  - a typedef for the per-lane flag vector.
- One sub-module, parity_lane_calc, is natural. It is purely combinational, with parameter LW and inputs lane data and odd_mode, and outputs the parity bit. It is instantiated LANES times via generate.

Test Plan (DATA_W = 32, LANES = 4):
- Even, generate only: s_data = 32'h01_03_07_FF, chk_en = 0 -> one cycle later m_valid = 1, m_par = 4'b1010 (lane3 = 1, lane2 = 0, lane1 = 1, lane0 = 0), m_err = 0.
- Odd mode, same data -> m_par = 4'b0101.
- Check mode, s_data = 32'h01_03_07_FF, odd_mode = 0, chk_en = 1, s_par = 4'b1011 -> m_err = 4'b0001, err_sticky = 1 next cycle, and it stays 1 through 10 clean beats.
- Backpressure: m_ready = 0 for 3 cycles while s_valid = 1 -> s_ready = 0, m_data held constant. Then m_ready = 1 for 8 back-to-back beats -> 8 transfers in 8 cycles, order preserved.
- Clear vs set: err_clr = 1 on the same edge as an erroring beat -> err_sticky = 1. err_clr alone next cycle -> err_sticky = 0.
- With PARITY_STREAM_ERR_CNT_EN and CNT_W = 2: 5 erroring beats -> err_cnt = 3 (saturated). Reset mid-stall -> m_valid = 0 and err_cnt = 0 next cycle.
